// File: rtl/keypad_col_scanner.sv
// Purpose: column scanner and whole-slot debouncer for a 4x4 active-low keypad; one key_valid pulse per accepted press.
// Latency: key_valid is registered, high the cycle after the DEBOUNCE_SCANS-th qualifying slot tick; rows see a 2-flop synchroniser.
// Backpressure: none; key_valid is a single-cycle pulse with key_code, and the consumer must take it that cycle.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   row[3:0]   keypad rows, active-low, asynchronous to clk
//   col[3:0]   column drive, active-low, exactly one bit low
//   key_code   {row_idx, col_idx} of the last accepted key
//   key_valid  one-cycle acceptance pulse
//   key_held   high from acceptance until the release is debounced
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-pulse key_valid every REPEAT_SCANS ticks while held.
module keypad_col_scanner #(
    parameter int SCAN_DIV       = 4096,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int                DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       DEB_N    = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {SCAN, CONFIRM, HOLD, RELEASE} state_t;

    logic [3:0]       row_meta_q, row_s_q;
    logic [DIV_W-1:0] div_q;
    state_t           state_q, state_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;

    logic       tick;
    logic [1:0] row_sel;
    logic       row_up;
    logic [3:0] cnt_inc;
    logic       accept, rel_done, adv;

    assign tick    = (div_q == DIV_LAST);
    assign row_up  = row_s_q[row_idx_q];
    assign cnt_inc = cnt_q + 4'd1;

    // Lowest-index low row wins when several rows are pressed together.
    always_comb begin
        row_sel = 2'd3;
        if (!row_s_q[0])      row_sel = 2'd0;
        else if (!row_s_q[1]) row_sel = 2'd1;
        else if (!row_s_q[2]) row_sel = 2'd2;
    end

    always_comb begin
        col = 4'b1111;
        col[col_idx_q] = 1'b0;
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int                REP_W = $clog2(REPEAT_SCANS + 1);
    localparam logic [REP_W-1:0] REP_N = REP_W'(REPEAT_SCANS);
    logic [REP_W-1:0] rep_q, rep_d;
    logic [REP_W-1:0] rep_inc;
    assign rep_inc = rep_q + 1'b1;
`else
    // Repeat interval only matters when auto-repeat is built in.
    logic unused_rep_cfg;
    assign unused_rep_cfg = (REPEAT_SCANS > 0);
`endif

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        accept      = 1'b0;
        rel_done    = 1'b0;
        adv         = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d       = rep_q;
`endif
        case (state_q)
            SCAN: begin
                if (tick) begin
                    if (row_s_q != 4'b1111) begin
                        // Column stays frozen on the detected key while it is confirmed.
                        row_idx_d = row_sel;
                        cnt_d     = 4'd1;
                        if (DEB_N <= 4'd1) accept  = 1'b1;
                        else               state_d = CONFIRM;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            CONFIRM: begin
                if (tick) begin
                    if (!row_up) begin
                        if (cnt_inc >= DEB_N) accept = 1'b1;
                        else                  cnt_d  = cnt_inc;
                    end else begin
                        cnt_d   = 4'd0;
                        adv     = 1'b1;
                        state_d = SCAN;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    if (row_up) begin
                        if (DEB_N <= 4'd1) begin
                            rel_done = 1'b1;
                        end else begin
                            cnt_d   = 4'd1;
                            state_d = RELEASE;
                        end
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_d = '0;
                    end else if (rep_inc == REP_N) begin
                        key_valid_d = 1'b1;
                        rep_d       = '0;
                    end else begin
                        rep_d = rep_inc;
`endif
                    end
                end
            end
            RELEASE: begin
`ifdef KEYPAD_AUTOREPEAT_EN
                rep_d = '0;
`endif
                if (tick) begin
                    if (row_up) begin
                        if (cnt_inc >= DEB_N) rel_done = 1'b1;
                        else                  cnt_d    = cnt_inc;
                    end else begin
                        // Release bounce: the key is still considered held.
                        cnt_d   = 4'd0;
                        state_d = HOLD;
                    end
                end
            end
            default: state_d = SCAN;
        endcase

        if (accept) begin
            state_d     = HOLD;
            key_valid_d = 1'b1;
            key_code_d  = {row_idx_d, col_idx_q};
            key_held_d  = 1'b1;
            cnt_d       = 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_d       = '0;
`endif
        end
        if (rel_done) begin
            state_d    = SCAN;
            key_held_d = 1'b0;
            cnt_d      = 4'd0;
            adv        = 1'b1;
        end
        if (adv) col_idx_d = col_idx_q + 2'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta_q  <= 4'b1111;
            row_s_q     <= 4'b1111;
            div_q       <= '0;
            state_q     <= SCAN;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            cnt_q       <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            row_meta_q  <= row;
            row_s_q     <= row_meta_q;
            div_q       <= tick ? '0 : div_q + 1'b1;
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rep_q <= '0;
        else        rep_q <= rep_d;
    end
`endif

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_col_scanner.sv
// Purpose: directed bench for keypad_col_scanner with a behavioural 4x4 keypad matrix model.
// Latency: expected acceptance/release cycle counts are hand-derived for SCAN_DIV=4, DEBOUNCE_SCANS=3.
// Backpressure: not applicable; key_valid pulses are counted at the falling edge.
module tb_keypad_col_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int REP      = 5;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int EXP_T6 = 5;
`else
    localparam int EXP_T6 = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row, col, key_code;
    logic        key_valid, key_held;
    logic [15:0] pressed;  // bit r*4+c set means key (row r, col c) is down

    int          n_checks = 0;
    int          n_fail   = 0;
    int          pulses   = 0;
    int          consec   = 0;
    logic [3:0]  last_code = 4'd0;
    logic        kv_prev  = 1'b0;
    int          n;

    keypad_col_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEB),
        .REPEAT_SCANS  (REP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a row reads low when a pressed key sits on the driven column.
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid) begin
            pulses++;
            last_code = key_code;
            if (kv_prev) consec++;
        end
        kv_prev = key_valid;
    end

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    task automatic wait_kv(output int cyc);
        cyc = 0;
        while (key_valid !== 1'b1 && cyc < 200) begin
            step(1);
            cyc++;
        end
    endtask

    task automatic wait_unheld(output int cyc);
        cyc = 0;
        while (key_held !== 1'b0 && cyc < 200) begin
            step(1);
            cyc++;
        end
    endtask

    task automatic wait_col(input logic [3:0] v);
        int cyc;
        cyc = 0;
        while (col !== v && cyc < 64) begin
            step(1);
            cyc++;
        end
        expect_eq("col_reached", col, v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        pressed = 16'h0000;
        reset   = 1'b0;

        // 1: idle scan order, one column every SCAN_DIV cycles
        do_reset();
        expect_eq("rst_col", col, 4'b1110);
        expect_eq("rst_code", key_code, 4'h0);
        expect_eq("rst_valid", key_valid, 1'b0);
        expect_eq("rst_held", key_held, 1'b0);
        step(4); expect_eq("scan_c1", col, 4'b1101);
        step(4); expect_eq("scan_c2", col, 4'b1011);
        step(4); expect_eq("scan_c3", col, 4'b0111);
        step(4); expect_eq("scan_c0", col, 4'b1110);
        expect_eq("idle_pulses", pulses, 0);

        // 2: clean press row2/col1; col1 driven at cycle 4, ticks at 8,12,16
        pressed[9] = 1'b1;
        do_reset();
        wait_kv(n);
        expect_eq("t2_latency", n, 16);
        expect_eq("t2_code", key_code, 4'h9);
        expect_eq("t2_held", key_held, 1'b1);
        pressed[9] = 1'b0;
        wait_unheld(n);
        expect_eq("t2_release_cyc", n, 12);
        expect_eq("t2_col_after", col, 4'b1011);
        expect_eq("t2_pulses", pulses, 1);
        expect_eq("t2_code_kept", key_code, 4'h9);

        // 3: row1/col2 low for one slot then high for one slot, three times
        for (int i = 0; i < 3; i++) begin
            wait_col(4'b1011);
            pressed[6] = 1'b1;
            step(4);
            expect_eq("t3_frozen", col, 4'b1011);
            pressed[6] = 1'b0;
            step(4);
            expect_eq("t3_resume", col, 4'b0111);
        end
        expect_eq("t3_pulses", pulses, 1);
        expect_eq("t3_held", key_held, 1'b0);

        // 4: hold row0/col3 (col3 driven now), then add row1/col0
        pressed[3] = 1'b1;
        wait_kv(n);
        expect_eq("t4_latency", n, 12);
        expect_eq("t4_code", key_code, 4'h3);
        pressed[4] = 1'b1;
        step(16);
        expect_eq("t4_pulses", pulses, 2);
        expect_eq("t4_held", key_held, 1'b1);
        expect_eq("t4_col", col, 4'b0111);
        expect_eq("t4_code_kept", key_code, 4'h3);

        // 5: reset while holding row0/col3
        pressed[4] = 1'b0;
        reset = 1'b0;
        #1;
        expect_eq("t5_col", col, 4'b1110);
        expect_eq("t5_code", key_code, 4'h0);
        expect_eq("t5_valid", key_valid, 1'b0);
        expect_eq("t5_held", key_held, 1'b0);
        step(1);
        reset = 1'b1;
        wait_kv(n);
        expect_eq("t5_latency", n, 24);
        expect_eq("t5_code_again", key_code, 4'h3);
        expect_eq("t5_held_again", key_held, 1'b1);
        pressed[3] = 1'b0;
        wait_unheld(n);
        expect_eq("t5_release_cyc", n, 12);
        step(8);
        expect_eq("t5_pulses", pulses, 3);

        // 6: hold row3/col3 for 20 ticks after acceptance, then release
        pressed[15] = 1'b1;
        do_reset();
        wait_kv(n);
        expect_eq("t6_latency", n, 24);
        expect_eq("t6_code", key_code, 4'hF);
        step(80);
        pressed[15] = 1'b0;
        wait_unheld(n);
        step(20);
        expect_eq("t6_pulses", pulses, 3 + EXP_T6);
        expect_eq("t6_last_code", last_code, 4'hF);
        expect_eq("no_back_to_back", consec, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
